mux_skid_buffer: RTL and testbench
==================================

Name: mux_skid_buffer

Overview:
- Pipeline stage directly downstream of the 5:1 16-bit operand mux; registers the selected 16-bit value together with its 3-bit select code (source tag).
- 2-entry skid buffer with valid/ready handshakes on both sides, so the operand path can stall without a combinational ready path back into the mux select logic.
- Provides synchronous flush for pipeline squash.
- Optional range check on the source tag.

Parameters:
- WIDTH, 16, data width of the mux output being buffered.
- SRC_W, 3, width of the source tag (mux select code).
- SRC_MAX, 4, highest legal tag value (five mux inputs, codes 0..4).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous squash; empties the buffer.
- in_data  input  WIDTH  mux output value.
- in_src  input  SRC_W  select code that produced in_data.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  buffer can accept; registered.
- out_data  output  WIDTH  head entry value.
- out_src  output  SRC_W  head entry tag.
- out_valid  output  1  head entry present.
- out_ready  input  1  downstream consumes head.
- occupancy  output  2  entries held: 0, 1 or 2.
- src_err  output  1  sticky illegal-tag flag.

Behaviour:
- Handshake signals:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - Both sides follow standard valid/ready rules: data is held stable while valid is high and ready is low.
- Reset (reset_n=0 at a clk edge):
  - state goes to EMPTY.
  - out_valid=0, out_data=0, out_src=0, occupancy=0, src_err=0, in_ready=1.
  - Any entry held or in flight mid-operation is discarded.
- Storage and decode:
  - Storage is a main register (drives the outputs) and a skid register.
  - in_ready = (state != FULL), taken from registered state only; there is no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- States and transitions:
  - EMPTY:
    - accept: load main, go to ONE.
  - ONE:
    - accept & !drain: load skid, go to FULL.
    - drain & !accept: go to EMPTY.
    - accept & drain: load main with the new entry, stay in ONE.
  - FULL:
    - in_ready=0, so no accept is possible.
    - drain: move skid to main, go to ONE.
    - otherwise hold.
- Latency:
  - 1 cycle from accept to out_valid when the buffer is EMPTY.
  - Entries always leave in arrival order.
- Throughput: 1 entry/cycle when out_ready is held high.
- Flush:
  - Priority is reset, then flush, then normal operation.
  - Goes to EMPTY and discards any accept in the same cycle; upstream still sees the handshake complete.
  - out_data and out_src keep their last values; only out_valid deasserts.
  - src_err is not cleared.
- occupancy: 0, 1 or 2, tracking EMPTY, ONE and FULL in the same cycle as the state register.

Optional Feature:
- Macro: MUX_SKID_SRC_CHECK_EN.
- Defined:
  - An accept with in_src > SRC_MAX completes the handshake but the entry is dropped (state unchanged by that accept).
  - src_err is set the next cycle and stays set until reset.
  - A simultaneous drain still proceeds.
- Undefined:
  - All tags are stored unchanged.
  - src_err is tied to 0.

Decomposition:
- Shared package mux_pkg holds:
  - the state enum {EMPTY, ONE, FULL};
  - the WIDTH and SRC_W defaults;
  - the constant SRC_MAX=4.
- One natural sub-module, skid_slot: a WIDTH+SRC_W register with load enable and synchronous active-low reset. It is instantiated twice, as the main and skid registers.

Test Plan:
- Reset: reset_n=0 for 2 cycles -> out_valid=0, out_data=0, in_ready=1, occupancy=0, src_err=0.
- Single pass: accept data=0x1234, src=2 with out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_src=2, then EMPTY.
- Stall fill: out_ready=0, accept 0xAAAA then 0x5555 -> occupancy=2, in_ready=0; raise out_ready -> 0xAAAA then 0x5555 on consecutive cycles.
- Streaming: 8 back-to-back entries with out_ready=1 -> 8 consecutive drains, in order, occupancy never exceeds 1.
- Flush: while FULL, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, and the flushed entry never appears.
- Illegal tag with MUX_SKID_SRC_CHECK_EN defined: accept src=5 -> entry dropped, src_err=1 and remains 1 after flush; with the macro undefined, the entry appears with src=5 and src_err=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the operand-mux skid buffer: state encoding,
// default widths and the highest legal source tag.
package mux_pkg;

    localparam int WIDTH   = 16;
    localparam int SRC_W   = 3;
    localparam int SRC_MAX = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_slot.sv
// One storage entry of the skid buffer: a W-bit register with load enable
// and synchronous active-low reset.
module skid_slot #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux_skid_buffer.sv
// Two-entry skid buffer behind the 5:1 operand mux, storing {tag, data}.
// Define MUX_SKID_SRC_CHECK_EN to drop entries with tags above SRC_MAX and flag them.
module mux_skid_buffer #(
    parameter int WIDTH   = mux_pkg::WIDTH,
`ifdef MUX_SKID_SRC_CHECK_EN
    parameter int SRC_MAX = mux_pkg::SRC_MAX,
`endif
    parameter int SRC_W   = mux_pkg::SRC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SRC_W-1:0] in_src,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SRC_W-1:0] out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic             src_err
);
    import mux_pkg::*;

    localparam int EW = WIDTH + SRC_W;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; while valid is high and ready low the payload is held.
    state_t          state;
    logic            accept;
    logic            drain;
    logic            take;
    logic            tag_ok;
    logic            load_main;
    logic            load_skid;
    logic [EW-1:0]   main_q;
    logic [EW-1:0]   skid_q;
    logic [EW-1:0]   main_d;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign take      = accept & tag_ok;

`ifdef MUX_SKID_SRC_CHECK_EN
    logic err_q;

    assign tag_ok  = (int'(in_src) <= SRC_MAX);
    assign src_err = err_q;

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (accept && !tag_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tag_ok  = 1'b1;
    assign src_err = 1'b0;
`endif

    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        if (!flush) begin
            unique case (state)
                EMPTY:   load_main = take;
                ONE: begin
                    load_main = take & drain;
                    load_skid = take & ~drain;
                end
                FULL:    load_main = drain;
                default: ;
            endcase
        end
    end

    // When FULL the only main load is the skid entry moving forward.
    assign main_d = (state == FULL) ? skid_q : {in_src, in_data};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= EMPTY;
            occupancy <= 2'd0;
        end else if (flush) begin
            state     <= EMPTY;
            occupancy <= 2'd0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (take) begin
                        state     <= ONE;
                        occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (take && !drain) begin
                        state     <= FULL;
                        occupancy <= 2'd2;
                    end else if (drain && !take) begin
                        state     <= EMPTY;
                        occupancy <= 2'd0;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state     <= ONE;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

    skid_slot #(.W(EW)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_main),
        .d       (main_d),
        .q       (main_q)
    );

    skid_slot #(.W(EW)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_skid),
        .d       ({in_src, in_data}),
        .q       (skid_q)
    );

    assign {out_src, out_data} = main_q;

endmodule

// File: tb/tb_mux_skid_buffer.sv
// Self-checking bench for mux_skid_buffer: directed scenarios followed by
// constrained-random traffic, checked against a FIFO-of-entries model.
module tb_mux_skid_buffer;

  localparam int W  = 16;
  localparam int SW = 3;
  localparam int SRC_LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_src;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic          src_err;

  mux_skid_buffer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_src    (in_src),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .src_err   (src_err)
  );

  always #5 clk = ~clk;

  // Model: the buffer is an ordered list of {tag, data} entries, at most two.
  logic [W+SW-1:0] exp_q[$];
  logic            exp_err = 1'b0;
  logic [W+SW-1:0] last_head = '0;
  logic            mon_en = 1'b0;
  int              checks = 0;
  int              errors = 0;

  function automatic bit tag_legal(input logic [SW-1:0] s);
`ifdef MUX_SKID_SRC_CHECK_EN
    return int'(s) <= SRC_LIMIT;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Stimulus bookkeeping: commit each completed upstream handshake to the model.
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      if (in_valid && in_ready && !flush) begin
        if (tag_legal(in_src)) exp_q.push_back({in_src, in_data});
        else exp_err = 1'b1;
      end
      if (flush) exp_q.delete();
    end
  end

  // Monitor: compare DUT outputs with the model every cycle, pop on drain.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_head = '0;
    end else if (mon_en) begin
      check("occupancy", 32'(occupancy), 32'(exp_q.size()));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("src_err", 32'(src_err), 32'(exp_err));
      if (exp_q.size() != 0) begin
        check("head", 32'({out_src, out_data}), 32'(exp_q[0]));
        last_head = exp_q[0];
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        check("idle_hold", 32'({out_src, out_data}), 32'(last_head));
      end
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s,
                      input logic f, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_src    = s;
    flush     = f;
    out_ready = r;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, r);
  endtask

  logic          held;
  logic          v_r;
  logic          f_r;
  logic [W-1:0]  d_r;
  logic [SW-1:0] s_r;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_src = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_src_err", 32'(src_err), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single pass
    step(1'b1, 16'h1234, 3'd2, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Stall fill, then release
    step(1'b1, 16'hAAAA, 3'd1, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 3'd3, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Streaming
    for (int i = 0; i < 8; i++)
      step(1'b1, W'($urandom), SW'(i % 5), 1'b0, 1'b1);
    idle(3, 1'b1);

    // Flush while FULL with an entry offered upstream
    step(1'b1, 16'h0A0A, 3'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0B0B, 3'd1, 1'b0, 1'b0);
    step(1'b1, 16'h0C0C, 3'd2, 1'b0, 1'b0);
    step(1'b1, 16'h0C0C, 3'd2, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Flush in ONE coinciding with an accepted entry
    step(1'b1, 16'h0D0D, 3'd3, 1'b0, 1'b0);
    step(1'b1, 16'h0E0E, 3'd4, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Illegal tag, then flush to show src_err survives it
    step(1'b1, 16'h0F0F, 3'd5, 1'b0, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 16'h1111, 3'd0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Random traffic obeying the upstream hold rule
    held = 1'b0;
    v_r = 1'b0; d_r = '0; s_r = '0; f_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      held = in_valid && !in_ready && !flush;
      @(posedge clk);
      #1;
      f_r = ($urandom_range(0, 19) == 0);
      if (!held) begin
        v_r = ($urandom_range(0, 3) != 0);
        d_r = W'($urandom);
        if (!f_r && $urandom_range(0, 9) == 0) s_r = SW'($urandom_range(5, 7));
        else s_r = SW'($urandom_range(0, SRC_LIMIT));
      end else if (!tag_legal(s_r)) begin
        f_r = 1'b0;
      end
      in_valid  = v_r;
      in_data   = d_r;
      in_src    = s_r;
      flush     = f_r;
      out_ready = ($urandom_range(0, 9) < 7);
    end
    idle(6, 1'b1);

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
